// File: rtl/render_rect_clip.sv
// Rectangle renderer with start/done handshake, ready backpressure, screen clipping,
// configurable border thickness and outline-only mode; streams one pixel per accepted cycle.
module render_rect_clip #(
  parameter int unsigned X_W      = 9,
  parameter int unsigned Y_W      = 8,
  parameter int unsigned COLOR_W  = 3,
  parameter int unsigned SCREEN_W = 320,
  parameter int unsigned SCREEN_H = 240,
  parameter int unsigned BT_W     = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [X_W-1:0]     origin_x,
  input  logic [Y_W-1:0]     origin_y,
  input  logic [X_W-1:0]     width,
  input  logic [Y_W-1:0]     height,
  input  logic [COLOR_W-1:0] back_color,
  input  logic [BT_W-1:0]    border_thick,
  input  logic [COLOR_W-1:0] border_color,
  input  logic               fill_en,
  input  logic               ready,
  output logic               busy,
  output logic               done,
  output logic [X_W-1:0]     x_stream,
  output logic [Y_W-1:0]     y_stream,
  output logic [COLOR_W-1:0] color_stream,
  output logic               writeEn
);

  localparam logic [X_W:0] SCR_W = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0] SCR_H = (Y_W+1)'(SCREEN_H);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SCAN, S_DONE} state_e;

  state_e state_q, state_d;

  // Rectangle description captured on start.
  logic [X_W-1:0]     ox_q, ox_d, w_q, w_d;
  logic [Y_W-1:0]     oy_q, oy_d, h_q, h_d;
  logic [COLOR_W-1:0] bc_q, bc_d, brc_q, brc_d;
  logic [BT_W-1:0]    t_q, t_d;
  logic               fill_q, fill_d;
  logic [X_W:0]       ex_q, ex_d;
  logic [Y_W:0]       ey_q, ey_d;

  // Presented pixel; x_q/y_q double as the scan counters.
  logic [X_W-1:0]     x_q, x_d;
  logic [Y_W-1:0]     y_q, y_d;
  logic [COLOR_W-1:0] col_q, col_d;
  logic               we_q, we_d, busy_q, busy_d, done_q, done_d;

  // Position following the current one in row-major order.
  logic [X_W:0]   x_inc;
  logic [Y_W:0]   y_inc;
  logic           wrap, last;
  logic [X_W-1:0] nx, px, dx;
  logic [Y_W-1:0] ny, py, dy;

  assign x_inc = {1'b0, x_q} + (X_W+1)'(1);
  assign y_inc = {1'b0, y_q} + (Y_W+1)'(1);
  assign wrap  = (x_inc == ex_q);
  assign last  = wrap && (y_inc == ey_q);
  assign nx    = wrap ? ox_q : x_inc[X_W-1:0];
  assign ny    = wrap ? y_inc[Y_W-1:0] : y_q;

  // The pixel about to be registered: the origin when leaving LOAD, else the successor.
  assign px = (state_q == S_LOAD) ? ox_q : nx;
  assign py = (state_q == S_LOAD) ? oy_q : ny;
  assign dx = px - ox_q;
  assign dy = py - oy_q;

  // Offsets are against the unclipped rectangle; dx+t>=w stands in for dx>=w-t without underflow.
  logic [X_W:0]       dx_w, tx;
  logic [Y_W:0]       dy_w, ty;
  logic               is_border, emit;
  logic [COLOR_W-1:0] pix_col;

  assign dx_w      = {1'b0, dx};
  assign dy_w      = {1'b0, dy};
  assign tx        = (X_W+1)'(t_q);
  assign ty        = (Y_W+1)'(t_q);
  assign is_border = (t_q != '0) &&
                     ((dx_w < tx) || (dx_w + tx >= {1'b0, w_q}) ||
                      (dy_w < ty) || (dy_w + ty >= {1'b0, h_q}));
  assign emit      = is_border || fill_q;
  assign pix_col   = is_border ? brc_q : bc_q;

  logic [X_W:0] sum_x;
  logic [Y_W:0] sum_y;
  logic         degenerate;

  assign sum_x      = {1'b0, ox_q} + {1'b0, w_q};
  assign sum_y      = {1'b0, oy_q} + {1'b0, h_q};
  assign degenerate = (w_q == '0) || (h_q == '0) ||
                      ({1'b0, ox_q} >= SCR_W) || ({1'b0, oy_q} >= SCR_H);

  always_comb begin
    // NOTE: every _d gets a hold default first so no branch can leave one unassigned and infer a latch.
    state_d = state_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    w_d     = w_q;
    h_d     = h_q;
    bc_d    = bc_q;
    brc_d   = brc_q;
    t_d     = t_q;
    fill_d  = fill_q;
    ex_d    = ex_q;
    ey_d    = ey_q;
    x_d     = x_q;
    y_d     = y_q;
    col_d   = col_q;
    we_d    = we_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          ox_d    = origin_x;
          oy_d    = origin_y;
          w_d     = width;
          h_d     = height;
          bc_d    = back_color;
          brc_d   = border_color;
          t_d     = border_thick;
          fill_d  = fill_en;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        ex_d = (sum_x > SCR_W) ? SCR_W : sum_x;
        ey_d = (sum_y > SCR_H) ? SCR_H : sum_y;
        if (degenerate) begin
          state_d = S_DONE;
        end else begin
          state_d = S_SCAN;
          x_d     = px;
          y_d     = py;
          col_d   = pix_col;
          we_d    = emit;
        end
      end
      S_SCAN: begin
        // A skipped pixel advances unconditionally; an emitted one waits for ready.
        if (!we_q || ready) begin
          if (last) begin
            state_d = S_DONE;
            x_d     = '0;
            y_d     = '0;
            col_d   = '0;
            we_d    = 1'b0;
          end else begin
            x_d   = px;
            y_d   = py;
            col_d = pix_col;
            we_d  = emit;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_LOAD) || (state_d == S_SCAN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      col_q   <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      col_q   <= col_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // NOTE: the captured rectangle is always written before use (IDLE->LOAD), so it carries no reset.
  always_ff @(posedge clk) begin
    ox_q   <= ox_d;
    oy_q   <= oy_d;
    w_q    <= w_d;
    h_q    <= h_d;
    bc_q   <= bc_d;
    brc_q  <= brc_d;
    t_q    <= t_d;
    fill_q <= fill_d;
    ex_q   <= ex_d;
    ey_q   <= ey_d;
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign x_stream     = x_q;
  assign y_stream     = y_q;
  assign color_stream = col_q;
  assign writeEn      = we_q;

endmodule

// File: tb/tb_render_rect_clip.sv
// Directed self-checking bench for render_rect_clip: ordering, colors, clipping,
// backpressure, degenerate rectangles, start-while-busy and reset mid-scan.
module tb_render_rect_clip;

  logic       clk = 1'b0;
  logic       reset, start, fill_en, ready;
  logic [8:0] origin_x, width;
  logic [7:0] origin_y, height;
  logic [2:0] back_color, border_color;
  logic [3:0] border_thick;
  logic       busy, done, writeEn;
  logic [8:0] x_stream;
  logic [7:0] y_stream;
  logic [2:0] color_stream;

  render_rect_clip dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .origin_x    (origin_x),
    .origin_y    (origin_y),
    .width       (width),
    .height      (height),
    .back_color  (back_color),
    .border_thick(border_thick),
    .border_color(border_color),
    .fill_en     (fill_en),
    .ready       (ready),
    .busy        (busy),
    .done        (done),
    .x_stream    (x_stream),
    .y_stream    (y_stream),
    .color_stream(color_stream),
    .writeEn     (writeEn)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Results of the most recent run.
  logic [31:0] wp [64];
  int          nw, done_at, busy_cnt, stalls;
  logic        got_done, hold_ok;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pk(input int x, input int y, input int c);
    return {12'd0, 9'(x), 8'(y), 3'(c)};
  endfunction

  // Pulse start for one cycle and follow the rectangle to its done pulse, then step
  // into the IDLE cycle after DONE. Cycle 1 is the one right after start was sampled.
  task automatic run(input int ox, input int oy, input int w, input int h, input int t,
                     input int bc, input int brc, input int fl,
                     input int stall_n, input int start_at);
    logic [31:0] held;
    int n;
    origin_x = 9'(ox); origin_y = 8'(oy); width = 9'(w); height = 8'(h);
    border_thick = 4'(t); back_color = 3'(bc); border_color = 3'(brc); fill_en = fl[0];
    ready = 1'b1; start = 1'b1;
    nw = 0; done_at = -1; busy_cnt = 0; stalls = 0; got_done = 1'b0; hold_ok = 1'b1;
    held = '0;
    tick();
    n = 1;
    for (int k = 0; k < 300 && !got_done; k++) begin
      if (done) begin
        got_done = 1'b1;
        done_at  = n;
      end else begin
        if (busy) busy_cnt++;
        if (n == start_at) begin
          start = 1'b1;
          origin_x = 9'd100; origin_y = 8'd100; width = 9'd7; height = 8'd7;
          back_color = 3'd7; border_thick = 4'd2; fill_en = 1'b0;
        end else begin
          start = 1'b0;
        end
        if (writeEn) begin
          if (nw == 0 && stalls < stall_n) begin
            if (stalls == 0) held = {12'd0, x_stream, y_stream, color_stream};
            else if ({12'd0, x_stream, y_stream, color_stream} !== held) hold_ok = 1'b0;
            ready = 1'b0;
            stalls++;
          end else begin
            ready = 1'b1;
            if (stalls != 0 && nw == 0 &&
                {12'd0, x_stream, y_stream, color_stream} !== held) hold_ok = 1'b0;
            if (nw < 64) wp[nw] = {12'd0, x_stream, y_stream, color_stream};
            nw++;
          end
        end else begin
          ready = 1'b1;
        end
        tick();
        n++;
      end
    end
    start = 1'b0;
    check("run_terminated", {31'd0, got_done}, 32'd1);
    check("busy_low_at_done", {31'd0, busy}, 32'd0);
    check("we_low_at_done", {31'd0, writeEn}, 32'd0);
    tick();
    check("done_one_cycle", {31'd0, done}, 32'd0);
  endtask

  logic [31:0] ex_x [12];
  logic [31:0] ex_y [12];
  int          cnt;

  initial begin
    ex_x = '{0, 1, 2, 3, 0, 3, 0, 3, 0, 1, 2, 3};
    ex_y = '{0, 0, 0, 0, 1, 1, 2, 2, 3, 3, 3, 3};

    reset = 1'b1; start = 1'b0; ready = 1'b1; fill_en = 1'b0;
    origin_x = '0; origin_y = '0; width = '0; height = '0;
    back_color = '0; border_color = '0; border_thick = '0;
    tick();
    tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_we", {31'd0, writeEn}, 32'd0);
    check("rst_pix", {12'd0, x_stream, y_stream, color_stream}, 32'd0);
    reset = 1'b0;
    tick();

    // Filled 3x2 at (10,20).
    run(10, 20, 3, 2, 0, 5, 2, 1, 0, 0);
    check("fill_writes", 32'(nw), 32'd6);
    check("fill_done_at", 32'(done_at), 32'd8);
    check("fill_busy_cycles", 32'(busy_cnt), 32'd7);
    check("fill_p0", wp[0], pk(10, 20, 5));
    check("fill_p1", wp[1], pk(11, 20, 5));
    check("fill_p2", wp[2], pk(12, 20, 5));
    check("fill_p3", wp[3], pk(10, 21, 5));
    check("fill_p4", wp[4], pk(11, 21, 5));
    check("fill_p5", wp[5], pk(12, 21, 5));

    // 4x4 at (0,0), t=1, filled: interior 2x2 in back_color.
    run(0, 0, 4, 4, 1, 1, 6, 1, 0, 0);
    check("brd_writes", 32'(nw), 32'd16);
    check("brd_done_at", 32'(done_at), 32'd18);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("brd_p%0d", i), wp[i],
            pk(i % 4, i / 4, ((i % 4) inside {1, 2} && (i / 4) inside {1, 2}) ? 1 : 6));
    end

    // Same, outline only: 12 writes over 16 SCAN cycles.
    run(0, 0, 4, 4, 1, 1, 6, 0, 0, 0);
    check("outl_writes", 32'(nw), 32'd12);
    check("outl_busy_cycles", 32'(busy_cnt), 32'd17);
    check("outl_done_at", 32'(done_at), 32'd18);
    for (int i = 0; i < 12; i++) begin
      check($sformatf("outl_p%0d", i), wp[i], pk(int'(ex_x[i]), int'(ex_y[i]), 6));
    end

    // Clipped at the bottom-right corner; clipped edges carry no border.
    run(318, 238, 5, 5, 1, 1, 6, 1, 0, 0);
    check("clip_writes", 32'(nw), 32'd4);
    check("clip_done_at", 32'(done_at), 32'd6);
    check("clip_p0", wp[0], pk(318, 238, 6));
    check("clip_p1", wp[1], pk(319, 238, 6));
    check("clip_p2", wp[2], pk(318, 239, 6));
    check("clip_p3", wp[3], pk(319, 239, 1));

    // Backpressure: ready low for 3 cycles on the first pixel.
    run(5, 5, 2, 1, 0, 4, 2, 1, 3, 0);
    check("bp_stalls", 32'(stalls), 32'd3);
    check("bp_hold", {31'd0, hold_ok}, 32'd1);
    check("bp_writes", 32'(nw), 32'd2);
    check("bp_done_at", 32'(done_at), 32'd7);
    check("bp_p0", wp[0], pk(5, 5, 4));
    check("bp_p1", wp[1], pk(6, 5, 4));

    // Degenerate rectangles go LOAD -> DONE with no writes.
    run(10, 10, 0, 4, 0, 3, 2, 1, 0, 0);
    check("w0_writes", 32'(nw), 32'd0);
    check("w0_done_at", 32'(done_at), 32'd2);
    run(400, 10, 4, 4, 0, 3, 2, 1, 0, 0);
    check("ox400_writes", 32'(nw), 32'd0);
    check("ox400_done_at", 32'(done_at), 32'd2);

    // t=3 on 4x4: every pixel is border.
    run(50, 60, 4, 4, 3, 1, 6, 1, 0, 0);
    check("thick_writes", 32'(nw), 32'd16);
    cnt = 0;
    for (int i = 0; i < 16; i++) if (wp[i][2:0] == 3'd6) cnt++;
    check("thick_border_px", 32'(cnt), 32'd16);
    check("thick_last", wp[15], pk(53, 63, 6));

    // Start during SCAN with different inputs is ignored.
    run(10, 20, 3, 2, 0, 5, 2, 1, 0, 3);
    check("sbusy_writes", 32'(nw), 32'd6);
    check("sbusy_done_at", 32'(done_at), 32'd8);
    check("sbusy_p0", wp[0], pk(10, 20, 5));
    check("sbusy_p5", wp[5], pk(12, 21, 5));

    // Reset mid-SCAN: outputs clear next cycle and no done follows.
    origin_x = 9'd20; origin_y = 8'd30; width = 9'd4; height = 8'd4;
    border_thick = 4'd0; back_color = 3'd3; fill_en = 1'b1; ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    check("mid_scan_we", {31'd0, writeEn}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mrst_busy", {31'd0, busy}, 32'd0);
    check("mrst_done", {31'd0, done}, 32'd0);
    check("mrst_we", {31'd0, writeEn}, 32'd0);
    check("mrst_pix", {12'd0, x_stream, y_stream, color_stream}, 32'd0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done || busy || writeEn) cnt++;
    end
    check("mrst_quiet", 32'(cnt), 32'd0);

    // Back in IDLE: a fresh rectangle still renders normally.
    run(7, 3, 1, 1, 1, 2, 5, 0, 0, 0);
    check("post_writes", 32'(nw), 32'd1);
    check("post_p0", wp[0], pk(7, 3, 5));
    check("post_done_at", 32'(done_at), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
